// File: rtl/dec_bbm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_bbm_pkg
//  Description : Shared state encoding and configuration check for the
//                registered break-before-make decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package dec_bbm_pkg;

  // Controller states of the break-before-make sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // True when OUT_W lines are addressable by a SEL_W-bit code
  function automatic bit out_w_fits(input int sel_w, input int out_w);
    return (out_w >= 2) && (sel_w < 31) && (out_w <= (1 << sel_w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_onehot.sv
`default_nettype none
// ============================================================================
//  Module      : dec_onehot
//  Description : Combinational index-to-one-hot decode with range flag.
//                Codes at or above OUT_W give an all-zero vector.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_onehot
  import dec_bbm_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic [SEL_W-1:0] idx_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             in_range_o
);

  genvar i;
  generate
    for (i = 0; i < OUT_W; i++) begin : g_line
      assign onehot_o[i] = (idx_i == SEL_W'(i));
    end
  endgenerate

  // One extra bit so OUT_W == 2**SEL_W compares correctly
  assign in_range_o = ({1'b0, idx_i} < (SEL_W+1)'(OUT_W));

endmodule
`default_nettype wire

// File: rtl/dec_bbm_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_bbm_reg
//  Description : Registered binary-to-one-hot decoder with break-before-make.
//                A change between two active lines holds all outputs low for
//                BLANK_CYC cycles before the new line asserts. Requests that
//                arrive while blanking are kept in a one-deep pending slot
//                (latest wins) and served once the current switch completes.
//                Optional macro DEC_BBM_ERR_EN adds an 'err' pulse output for
//                out-of-range codes and pending-slot overwrites.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_bbm_reg
  import dec_bbm_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int OUT_W     = 8,
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_vld,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_off,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done
`ifdef DEC_BBM_ERR_EN
  ,
  output logic             err
`endif
);

  localparam bit C_CFG_OK = out_w_fits(SEL_W, OUT_W) && (BLANK_CYC >= 0) &&
                            (BLANK_CYC <= 255) &&
                            ((CNT_W >= 8) || (BLANK_CYC < (1 << CNT_W)));
  localparam logic [CNT_W-1:0] C_CNT_LOAD =
    (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

  generate
    if (!C_CFG_OK) begin : g_cfg_bad
      $error("dec_bbm_reg: illegal SEL_W/OUT_W/BLANK_CYC/CNT_W combination");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cur_valid_q, cur_valid_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]   tgt_sel_q, tgt_sel_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OUT_W-1:0]   w_in_hot;
  logic               w_in_rng;
  logic [SEL_W-1:0]   w_aux_idx;
  logic [OUT_W-1:0]   w_aux_hot;
  logic               w_aux_rng;
  logic               w_in_req;
  logic [SEL_W-1:0]   w_req_sel;
  logic [OUT_W-1:0]   w_req_hot;

  // Decode of the live request code
  dec_onehot #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_dec_in (
    .idx_i      (in_sel),
    .onehot_o   (w_in_hot),
    .in_range_o (w_in_rng)
  );

  // Second decoder serves the blanking target and the pending slot
  assign w_aux_idx = (state_q == ST_BLANK) ? tgt_sel_q : pend_sel_q;

  dec_onehot #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_dec_aux (
    .idx_i      (w_aux_idx),
    .onehot_o   (w_aux_hot),
    .in_range_o (w_aux_rng)
  );

  // A usable request: strobe with an in-range code and no de-assert command
  assign w_in_req = in_vld && w_in_rng && !in_off;

  // Next-state and output logic of the break-before-make sequencer
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cur_valid_d = cur_valid_q;
    cur_sel_d   = cur_sel_q;
    tgt_sel_d   = tgt_sel_q;
    pend_vld_d  = pend_vld_q;
    pend_sel_d  = pend_sel_q;
    cnt_d       = cnt_q;
    // A live request takes precedence over an older pending one
    w_req_sel   = w_in_req ? in_sel : pend_sel_q;
    w_req_hot   = w_in_req ? w_in_hot : w_aux_hot;

    case (state_q)
      ST_IDLE: begin
        if (in_off) begin
          out_d       = '0;
          cur_valid_d = 1'b0;
          pend_vld_d  = 1'b0;
          done_d      = 1'b1;
        end else if (w_in_req || (pend_vld_q && w_aux_rng)) begin
          pend_vld_d = 1'b0;
          if (cur_valid_q && (w_req_sel == cur_sel_q)) begin
            done_d = 1'b1;
          end else if (!cur_valid_q || (BLANK_CYC == 0)) begin
            // Nothing active, or no gap wanted: switch straight away
            out_d       = w_req_hot;
            cur_sel_d   = w_req_sel;
            cur_valid_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            out_d     = '0;
            busy_d    = 1'b1;
            cnt_d     = C_CNT_LOAD;
            tgt_sel_d = w_req_sel;
            state_d   = ST_BLANK;
          end
        end
      end

      ST_BLANK: begin
        if (in_off) begin
          out_d       = '0;
          busy_d      = 1'b0;
          cnt_d       = '0;
          pend_vld_d  = 1'b0;
          cur_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          if (w_in_req) begin
            pend_vld_d = 1'b1;
            pend_sel_d = in_sel;
          end
          if (cnt_q == '0) begin
            // Gap complete: new line asserts together with done
            out_d       = w_aux_hot;
            cur_sel_d   = tgt_sel_q;
            cur_valid_d = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DRIVE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_DRIVE: begin
        state_d = ST_IDLE;
        if (in_off) begin
          out_d       = '0;
          cur_valid_d = 1'b0;
          pend_vld_d  = 1'b0;
          done_d      = 1'b1;
        end else if (w_in_req) begin
          pend_vld_d = 1'b1;
          pend_sel_d = in_sel;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      tgt_sel_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_sel_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cur_valid_q <= cur_valid_d;
      cur_sel_q   <= cur_sel_d;
      tgt_sel_q   <= tgt_sel_d;
      pend_vld_q  <= pend_vld_d;
      pend_sel_q  <= pend_sel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef DEC_BBM_ERR_EN
  logic err_q, err_d;

  // Flag bad codes and overwrites of a still-valid pending slot
  always_comb begin
    err_d = in_vld && !in_off &&
            (!w_in_rng || ((state_q != ST_IDLE) && pend_vld_q));
  end

  // One-cycle error pulse register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: doc/dec_bbm_reg.md
Name: dec_bbm_reg

Overview:
Parametrised, registered binary-to-one-hot decoder. It replaces the earlier combinational 3-to-8 decoder, which risked latch inference, with explicit flip-flops. Adds break-before-make switching: every change between two active selections forces the output to all-zero for BLANK_CYC cycles before the new line asserts. Drives select lines of external switches or muxes, where two simultaneously active lines are forbidden.

Parameters:
SEL_W, 3, select code width
OUT_W, 8, number of one-hot output lines; legal range 2..2**SEL_W
BLANK_CYC, 2, all-zero gap in cycles between old and new line; legal range 0..255
CNT_W, 8, blanking counter width; must hold BLANK_CYC

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
in_vld  in  1  request strobe; in_sel sampled when high
in_sel  in  SEL_W  requested line index
in_off  in  1  request to de-assert all lines; priority over in_vld in same cycle
out  out  OUT_W  registered one-hot (or all-zero) select lines
busy  out  1  high while in BLANK state
done  out  1  one-cycle pulse when out reaches the requested value

Behaviour:
- Reset (asynchronous, sys_rst_n=0): out=0, busy=0, done=0, state IDLE, pending cleared, cur_valid=0.
- States: IDLE, BLANK, DRIVE.
- IDLE, in_off=1: out<=0 next cycle, cur_valid<=0, done pulses that cycle. Any pending request is discarded.
- IDLE, in_vld=1, in_sel==current line with cur_valid=1: no output change; done pulses next cycle.
- IDLE, in_vld=1, cur_valid=0: no blanking. out<=1<<in_sel next cycle (latency 1), done pulses with it.
- IDLE, in_vld=1, new line differs from current:
  - BLANK_CYC=0: out switches directly next cycle; done pulses with it.
  - BLANK_CYC>0: out<=0 and busy<=1 next cycle, counter loads BLANK_CYC-1, state BLANK.
- BLANK: out=0; counter decrements each cycle. At 0 go to DRIVE. out shows the new line at cycle 1+BLANK_CYC after the request; done pulses then; busy drops in the same cycle.
- DRIVE is a transient single-cycle load state, then IDLE.
- Requests while busy: in_vld writes a one-deep pending register; later requests overwrite earlier ones, so the latest wins. After DRIVE, a valid pending entry is processed as a fresh IDLE request in the next cycle.
- in_off while busy aborts blanking: out stays 0, counter cleared, pending cleared, return to IDLE, done pulses next cycle.
- Out-of-range in_sel (>=OUT_W): request ignored; out and state unchanged; no done pulse.
- Invariant: popcount(out) <= 1 in every cycle.
- Reset asserted mid-BLANK: immediate return to reset values.

Optional Feature:
Macro DEC_BBM_ERR_EN.
- Defined: adds output port err (1 bit, reset 0). err pulses one cycle after an out-of-range in_sel or a pending-register overwrite.
- Not defined: no err port; such events are silently dropped as described above.

Decomposition:
- Package dec_bbm_pkg: state encoding typedef (IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2) and a constant function checking OUT_W <= 2**SEL_W.
- One natural sub-module: dec_onehot (combinational index-to-one-hot with range check), reused by the pending path.

Test Plan:
- Defaults; after reset, in_vld with in_sel=3 -> out=8'b0000_1000 one cycle later, done=1, no blanking.
- out=8'h08; request in_sel=5 at cycle t -> out=0 at t+1 and t+2, busy=1; out=8'h20 and done=1 at t+3.
- During blanking, requests sel=1 then sel=6 -> sel=6 wins; out goes 8'h20 -> 0 for 2 cycles -> 8'h40; 8'h02 never appears.
- OUT_W=6: in_sel=7 -> out unchanged, no done; with DEC_BBM_ERR_EN defined, err=1 for one cycle.
- in_off and in_vld together mid-BLANK -> out stays 0, IDLE next cycle, done pulse; then same-sel request -> no blanking.
- Reset asserted mid-BLANK and BLANK_CYC=0 run -> all outputs 0 immediately; direct switch 8'h01 -> 8'h80 in one cycle. Assertion popcount(out)<=1 holds throughout.
